// File: rtl/ps2_scancode_decoder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package  : ps2_pkg                                                     |
// | Purpose  : Shared types and constants for the PS/2 scan-code decoder:  |
// |            prefix codes, prefix FSM states, the key event record and   |
// |            the number-key lookup used by the digit history.            |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  typedef enum logic [1:0] {
    PFX_IDLE    = 2'd0,
    PFX_EXT     = 2'd1,
    PFX_BRK     = 2'd2,
    PFX_EXT_BRK = 2'd3
  } prefix_state_t;

  // "release" is a reserved word, so the break flag is called released.
  typedef struct packed {
    logic [7:0] code;
    logic       released;
    logic       extended;
  } ps2_event_t;

  // Returns {hit, digit}; hit is set only for the ten number-row keys.
  function automatic logic [4:0] ps2_digit(input logic [7:0] code);
    logic [4:0] result;
    result = 5'd0;
    case (code)
      8'h45:   result = {1'b1, 4'd0};
      8'h16:   result = {1'b1, 4'd1};
      8'h1E:   result = {1'b1, 4'd2};
      8'h26:   result = {1'b1, 4'd3};
      8'h25:   result = {1'b1, 4'd4};
      8'h2E:   result = {1'b1, 4'd5};
      8'h36:   result = {1'b1, 4'd6};
      8'h3D:   result = {1'b1, 4'd7};
      8'h3E:   result = {1'b1, 4'd8};
      8'h46:   result = {1'b1, 4'd9};
      default: result = 5'd0;
    endcase
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_scancode_decoder_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface : ps2_scancode_decoder_if                                    |
// | Purpose   : Frame input, event FIFO read side and status outputs of   |
// |             the scan-code decoder. master = frame source / host,       |
// |             slave = decoder.                                           |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
interface ps2_scancode_decoder_if #(
  parameter int ERR_CNT_WIDTH = 8
);
  logic                     frame_valid;
  logic [10:0]              frame_data;
  logic                     evt_pop;
  logic                     evt_valid;
  logic [7:0]               evt_code;
  logic                     evt_release;
  logic                     evt_extended;
  logic                     fifo_full;
  logic                     overflow_sticky;
  logic                     frame_error;
  logic [ERR_CNT_WIDTH-1:0] error_count;
  logic [23:0]              digit_history;
  logic [2:0]               digit_count;

  modport master (
    output frame_valid, frame_data, evt_pop,
    input  evt_valid, evt_code, evt_release, evt_extended, fifo_full,
           overflow_sticky, frame_error, error_count, digit_history, digit_count
  );

  modport slave (
    input  frame_valid, frame_data, evt_pop,
    output evt_valid, evt_code, evt_release, evt_extended, fifo_full,
           overflow_sticky, frame_error, error_count, digit_history, digit_count
  );
endinterface
`default_nettype wire

// File: rtl/ps2_scancode_decoder_event_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : ps2_event_fifo                                              |
// | Purpose  : Synchronous FIFO of key events. A push into a full FIFO is  |
// |            accepted only when a pop frees a slot in the same cycle;    |
// |            otherwise it is dropped and flagged on drop.                |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset_neg,
  input  logic       push,
  input  ps2_event_t push_data,
  input  logic       pop,
  output ps2_event_t head,
  output logic       full,
  output logic       empty,
  output logic       drop
);
  localparam int                c_addr_w = $clog2(DEPTH);
  localparam logic [c_addr_w:0] c_depth  = DEPTH[c_addr_w:0];

  ps2_event_t            r_mem [DEPTH];
  logic [c_addr_w-1:0]   r_wr_ptr;
  logic [c_addr_w-1:0]   r_rd_ptr;
  logic [c_addr_w:0]     r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_depth);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign drop      = push && !w_do_push;
  assign head      = r_mem[r_rd_ptr];

  // Storage array; written only on an accepted push, never reset.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : ps2_scancode_decoder                                        |
// | Purpose  : Validates PS/2 frames (start, stop, odd parity), folds E0 / |
// |            F0 prefixes into single key events, queues them for the    |
// |            host and keeps a six-digit history of number-key presses.   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset_neg,
  ps2_scancode_decoder_if.slave  bus
);
  prefix_state_t            r_state;
  logic                     r_emit;
  ps2_event_t               r_emit_evt;
  logic                     r_frame_error;
  logic [ERR_CNT_WIDTH-1:0] r_error_count;
  logic [23:0]              r_digit_history;
  logic [2:0]               r_digit_count;
  logic                     r_overflow_sticky;

  logic       w_frame_ok;
  logic       w_good;
  logic       w_bad;
  logic [7:0] w_code;
  logic       w_is_ext;
  logic       w_is_brk;
  logic       w_pfx_ext;
  logic       w_pfx_brk;
  logic [4:0] w_digit;
  logic       w_digit_push;
  ps2_event_t w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_drop;

  assign w_code     = bus.frame_data[8:1];
  assign w_frame_ok = !bus.frame_data[0] && bus.frame_data[10] && (^bus.frame_data[9:1]);
  assign w_good     = bus.frame_valid && w_frame_ok;
  assign w_bad      = bus.frame_valid && !w_frame_ok;
  assign w_is_ext   = (w_code == PS2_EXT_PREFIX);
  assign w_is_brk   = (w_code == PS2_BRK_PREFIX);
  assign w_pfx_ext  = (r_state == PFX_EXT) || (r_state == PFX_EXT_BRK);
  assign w_pfx_brk  = (r_state == PFX_BRK) || (r_state == PFX_EXT_BRK);
  assign w_digit    = ps2_digit(w_code);

  // Only a plain make (no pending prefix) of a number key enters the history.
  assign w_digit_push = w_good && !w_is_ext && !w_is_brk && !w_pfx_ext && !w_pfx_brk && w_digit[4];

  // Prefix FSM: accumulates E0/F0 and emits one registered event per key code.
  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      r_state       <= PFX_IDLE;
      r_emit        <= 1'b0;
      r_emit_evt    <= '0;
      r_frame_error <= 1'b0;
    end else begin
      r_emit        <= 1'b0;
      r_frame_error <= 1'b0;
      if (w_bad) begin
        r_frame_error <= 1'b1;
        r_state       <= PFX_IDLE;
      end else if (w_good) begin
        if (w_is_ext) begin
          r_state <= w_pfx_brk ? PFX_EXT_BRK : PFX_EXT;
        end else if (w_is_brk) begin
          r_state <= w_pfx_ext ? PFX_EXT_BRK : PFX_BRK;
        end else begin
          r_emit              <= 1'b1;
          r_emit_evt.code     <= w_code;
          r_emit_evt.released <= w_pfx_brk;
          r_emit_evt.extended <= w_pfx_ext;
          r_state             <= PFX_IDLE;
        end
      end
    end
  end

  // Saturating count of rejected frames.
  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      r_error_count <= '0;
    end else if (w_bad && (r_error_count != '1)) begin
      r_error_count <= r_error_count + 1'b1;
    end
  end

  // Digit history shifts newest into the low nibble; independent of FIFO space.
  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      r_digit_history <= '0;
      r_digit_count   <= '0;
    end else if (w_digit_push) begin
      r_digit_history <= {r_digit_history[19:0], w_digit[3:0]};
      if (r_digit_count != 3'd6) r_digit_count <= r_digit_count + 3'd1;
    end
  end

  // Remember any dropped event until the next reset.
  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      r_overflow_sticky <= 1'b0;
    end else if (w_drop) begin
      r_overflow_sticky <= 1'b1;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_event_fifo (
    .clock     (clock),
    .reset_neg (reset_neg),
    .push      (r_emit),
    .push_data (r_emit_evt),
    .pop       (bus.evt_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .drop      (w_drop)
  );

  // Head fields are forced to zero while empty so nothing undefined leaves the block.
  assign bus.evt_valid       = !w_empty;
  assign bus.evt_code        = w_empty ? 8'h00 : w_head.code;
  assign bus.evt_release     = !w_empty && w_head.released;
  assign bus.evt_extended    = !w_empty && w_head.extended;
  assign bus.fifo_full       = w_full;
  assign bus.overflow_sticky = r_overflow_sticky;
  assign bus.frame_error     = r_frame_error;
  assign bus.error_count     = r_error_count;
  assign bus.digit_history   = r_digit_history;
  assign bus.digit_count     = r_digit_count;

endmodule
`default_nettype wire

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Downstream stage of the PS/2 receive frame engine; consumes each completed 11-bit frame plus a one-cycle valid strobe.
- Checks the frame's start bit, stop bit and odd parity.
- Folds E0 (extended) and F0 (break) prefixes into a single key event, then buffers events in a small synchronous FIFO for the host logic.
- Keeps a 6-digit history of number-key presses for the six seven-segment displays.

Parameters:
FIFO_DEPTH, 8, event FIFO entries (power of 2, >=2)
ERR_CNT_WIDTH, 8, width of saturating frame-error counter

Ports:
clock  input  1  system clock
reset_neg  input  1  asynchronous active-low reset
frame_valid  input  1  one-cycle strobe; frame_data holds a complete frame
frame_data  input  11  [0]=start, [8:1]=data LSB-first, [9]=parity, [10]=stop
evt_pop  input  1  consume the head event (ignored when FIFO is empty)
evt_valid  output  1  FIFO not empty
evt_code  output  8  head event scan code
evt_release  output  1  head event is a break (F0-prefixed)
evt_extended  output  1  head event is E0-prefixed
fifo_full  output  1  FIFO holds FIFO_DEPTH entries
overflow_sticky  output  1  an event was dropped since reset
frame_error  output  1  one-cycle pulse on a rejected frame
error_count  output  ERR_CNT_WIDTH  count of rejected frames, saturating
digit_history  output  24  six 4-bit BCD digits; [3:0]=newest
digit_count  output  3  valid digits in history, saturates at 6

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: all outputs 0; FIFO empty; prefix state PFX_IDLE.
- Frame check: frame_data is accepted only when [0]==0, [10]==1 and XOR of [9:1] is 1 (odd parity). Otherwise the frame is rejected.
- Rejected frame, in the cycle after frame_valid:
  - frame_error=1 for exactly one cycle;
  - error_count increments, holding at all-ones;
  - prefix state returns to PFX_IDLE;
  - nothing is pushed to the FIFO.
- Prefix FSM, with registered flags ext and brk (all transitions take place on a good frame only):
  - PFX_IDLE: E0 -> PFX_EXT; F0 -> PFX_BRK; any other code -> emit, stay in PFX_IDLE.
  - PFX_EXT: E0 -> stay in PFX_EXT; F0 -> PFX_EXT_BRK; any other code -> emit with ext=1, go to PFX_IDLE.
  - PFX_BRK: F0 -> stay in PFX_BRK; E0 -> PFX_EXT_BRK; any other code -> emit with brk=1, go to PFX_IDLE.
  - PFX_EXT_BRK: E0 or F0 -> stay; any other code -> emit with ext=1 and brk=1, go to PFX_IDLE.
- Emit and FIFO push:
  - The FIFO is written on the clock edge after frame_valid; evt_valid rises the following cycle. This gives 2-cycle latency from frame_valid to evt_valid.
  - evt_code, evt_release and evt_extended always show the head entry. Their values are don't-care when the FIFO is empty.
- FIFO rules:
  - Push and pop in the same cycle while full: both happen, and the count is unchanged.
  - Push while full with no pop: the event is dropped and overflow_sticky is set. overflow_sticky is cleared only by reset.
  - Pop while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Digit history:
  - Triggered on emit of a non-extended make (brk=0, ext=0) whose code is in the digit table: 45->0, 16->1, 1E->2, 26->3, 25->4, 2E->5, 36->6, 3D->7, 3E->8, 46->9.
  - Action: digit_history <= {digit_history[19:0], digit}; digit_count increments, saturating at 6.
  - Breaks, extended codes and non-digit codes leave the history unchanged.
  - The history updates even when the FIFO push is dropped.
- Back-to-back frames: frame_valid may assert on consecutive cycles; each frame is fully processed.
- Reset mid-sequence (e.g. after E0): the FSM returns to PFX_IDLE and the pending prefix is discarded.

Decomposition:
- Shared package ps2_pkg:
  - constants PS2_EXT_PREFIX=8'hE0 and PS2_BRK_PREFIX=8'hF0;
  - enum prefix_state_t {PFX_IDLE, PFX_EXT, PFX_BRK, PFX_EXT_BRK};
  - packed struct ps2_event_t {code[7:0], release, extended};
  - function ps2_digit(code) returning {hit, digit[3:0]}.
- One sub-module, ps2_event_fifo: a parameterised synchronous FIFO of ps2_event_t with push, pop, full, empty and drop detect.

Test Plan:
- Good frame 0x16 (parity 0, stop 1) -> two cycles later evt_valid=1, evt_code=16, release=0, extended=0; digit_history[3:0]=1; digit_count=1.
- Frames F0 then 16 -> exactly one event: code 16, release=1, extended=0; digit_history unchanged.
- Frames E0, F0, 75 -> exactly one event: code 75, extended=1, release=1. Frames E0 then 70 -> code 70, extended=1; no digit update.
- Frame 0x45 with wrong parity -> frame_error pulses once, error_count=1, no event. A following good 0x45 -> digit 0 is shifted in. Bad start or bad stop bit behaves the same way.
- Nine makes with evt_pop held 0 (FIFO_DEPTH=8) -> fifo_full=1 after the 8th, overflow_sticky=1 after the 9th. Pop 8 times -> codes return in order and evt_valid=0. A push and pop in the same cycle while full keeps fifo_full=1.
- Digit keys 1..7, then assert reset_neg low in the middle of an E0 prefix -> before reset digit_history=24'h234567 and digit_count=6. After reset all outputs are 0, and the next frame 16 emits with extended=0.
